// File: rtl/plab4_net_router_output_ctrl_tdm.sv
// plab4_net_router_output_ctrl_tdm: router output-port arbiter, round-robin or TDM-partitioned by security domain
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   reqs_i[2:0]          per-input-controller request, already qualified by in_val
//   in_domains_i         domain tag of each requester's head message, i*c_dom_nbits +: c_dom_nbits
//   tp_en_i              1 = time-multiplex the port between domains, 0 = plain round-robin
//   out_rdy_i            downstream can accept a message this cycle
//   grants_o[2:0]        one-hot grant (transfer happens this cycle) or zero
//   out_val_o            some requester is eligible
//   out_sel_o[1:0]       index of the selected requester, drives the output mux
//   cur_domain_o         domain owning the current time slot
module plab4_net_router_output_ctrl_tdm #(
    parameter int p_num_domains = 2,
    parameter int p_slot_len    = 4,
    localparam int c_dom_nbits  = (p_num_domains > 1) ? $clog2(p_num_domains) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               reqs_i,
    input  logic [3*c_dom_nbits-1:0] in_domains_i,
    input  logic                     tp_en_i,
    input  logic                     out_rdy_i,
    output logic [2:0]               grants_o,
    output logic                     out_val_o,
    output logic [1:0]               out_sel_o,
    output logic [c_dom_nbits-1:0]   cur_domain_o
);

    localparam int c_slot_nbits = (p_slot_len > 1) ? $clog2(p_slot_len) : 1;

    logic [c_slot_nbits-1:0] slot_cnt_q, slot_cnt_d;
    logic [c_dom_nbits-1:0]  cur_domain_q, cur_domain_d;
    logic [2:0]              prio_q [p_num_domains];
    logic [2:0]              prio_d [p_num_domains];

    logic [2:0]             elig;
    logic [c_dom_nbits-1:0] act_idx;
    logic [2:0]             act;
    logic [1:0]             start, c1, c2, sel;
    logic                   slot_wrap, any, fire;

    // The slot schedule free-runs regardless of traffic so grant timing of
    // one domain never depends on another domain's behaviour.
    always_comb begin
        slot_wrap    = slot_cnt_q == c_slot_nbits'(p_slot_len - 1);
        slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        cur_domain_d = !slot_wrap ? cur_domain_q
                     : (cur_domain_q == c_dom_nbits'(p_num_domains - 1)) ? '0
                     : cur_domain_q + 1'b1;
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            elig[i] = reqs_i[i] & (~tp_en_i | (in_domains_i[i*c_dom_nbits +: c_dom_nbits] == cur_domain_q));
        act_idx = tp_en_i ? cur_domain_q : '0;
        act     = prio_q[act_idx];
        // Scan order starts at the pointer's set bit and wraps modulo 3.
        start   = act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd0;
        c1      = (start == 2'd2) ? 2'd0 : start + 2'd1;
        c2      = (start == 2'd0) ? 2'd2 : start - 2'd1;
        sel     = elig[start] ? start : elig[c1] ? c1 : elig[c2] ? c2 : 2'd0;
        any     = ~reset & (|elig);
        fire    = any & out_rdy_i;
    end

    assign out_val_o    = any;
    assign out_sel_o    = any ? sel : 2'd0;
    assign grants_o     = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{fire}};
    assign cur_domain_o = reset ? '0 : cur_domain_q;

    // Only the pointer that arbitrated this cycle moves, to just past the winner.
    always_comb begin
        prio_d = prio_q;
        if (fire)
            prio_d[act_idx] = {sel == 2'd1, sel == 2'd0, sel == 2'd2};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            cur_domain_q <= '0;
            for (int d = 0; d < p_num_domains; d++)
                prio_q[d] <= 3'b001;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            cur_domain_q <= cur_domain_d;
            prio_q       <= prio_d;
        end
    end

endmodule

// File: doc/plab4_net_router_output_ctrl_tdm.md
# plab4_net_router_output_ctrl_tdm

Output-port arbiter for one router output (west, terminal or east). It shares that output among the router's three input controllers. Each input controller presents a `reqs` bit and receives a one-hot `grants` vector. When timing-channel protection is enabled, the block time-multiplexes the port between security domains using a free-running slot schedule, so one domain's traffic cannot change another domain's grant timing. When protection is disabled, it is a plain round-robin arbiter.

## Interface
- `p_num_domains`, 2: number of security domains; must be >= 2.
- `p_slot_len`, 4: cycles per domain time slot; must be >= 1.
- `c_dom_nbits`, `$clog2(p_num_domains)`: domain tag width; minimum 1.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `reqs` input 3: request from input controller i on bit i; already qualified by that controller's `in_val`.
- `in_domains` input 3*c_dom_nbits: domain tag of requester i's head message, at `[i*c_dom_nbits +: c_dom_nbits]`.
- `tp_en` input 1: 1 = TDM protection on, 0 = plain round-robin.
- `out_rdy` input 1: downstream (neighbour router or terminal) can accept a message this cycle.
- `grants` output 3: one-hot grant, or zero; grant implies transfer this cycle.
- `out_val` output 1: an eligible request exists.
- `out_sel` output 2: index of the selected requester, driving the output mux.
- `cur_domain` output c_dom_nbits: domain owning the current slot.

## Operation
- **State**
  - `slot_cnt`: range 0..p_slot_len-1.
  - `cur_domain`: range 0..p_num_domains-1.
  - `prio[d]`: one 3-bit one-hot priority pointer per domain.
- **Reset state:** `slot_cnt`=0, `cur_domain`=0, every `prio[d]`=3'b001.
- **Slot schedule:** runs every cycle, independent of traffic, `tp_en` and `out_rdy`.
  - `slot_cnt` increments each cycle.
  - When `slot_cnt` = p_slot_len-1, `slot_cnt` wraps to 0 and `cur_domain` increments, wrapping p_num_domains-1 -> 0.
- **Eligibility:** `elig[i] = reqs[i] & (tp_en ? in_domains[i]==cur_domain : 1)`.
- **Active pointer:** `prio[cur_domain]` when `tp_en`=1; `prio[0]` when `tp_en`=0.
- **Selection:** round-robin. The first eligible requester found by scanning upward from the active pointer's set bit, modulo 3, is selected.
  - `out_sel` is that requester's index. It is 0 when none is eligible.
  - `out_val` = |elig.
  - `grants` = one-hot(`out_sel`) when `out_val` & `out_rdy`, otherwise 3'b000.
- **Pointer update:** on a cycle with a nonzero grant to requester i, the active pointer becomes one-hot((i+1) mod 3) at the next edge. No other pointer changes.
- **Stall and toggle rules:**
  - `out_rdy`=0: no grant, no pointer update, slot schedule continues.
  - `tp_en` toggling: takes effect combinationally in the same cycle. There is no state flush and pointers are preserved.
- **Arithmetic:** `slot_cnt` width is `$clog2(p_slot_len)`, minimum 1. Wrap comparisons are exact, so there is no overflow reliance.

## Timing
- Request-to-grant is combinational: zero cycles from `reqs`/`in_domains`/`out_rdy`/`tp_en` to `grants`/`out_val`/`out_sel`.
- State updates only on the rising edge of `clk`.
- **While `reset`=1:** `grants`=0, `out_val`=0, `out_sel`=0, `cur_domain`=0. Outputs are forced regardless of inputs.
- **Reset deassertion:** the first post-reset cycle is slot 0, domain 0, `slot_cnt`=0.
- **Reset mid-slot:** counters and all pointers return to reset values on the next edge.
- **Last cycle of a slot:** a grant is still legal there, because messages are single-flit and the transfer completes that cycle. The next cycle belongs to the next domain.
- **Slot-boundary requests:** a request whose domain matches the next slot's domain is granted in that slot's first cycle at the earliest.
- **Worst-case wait for a requester with `tp_en`=1:** (p_num_domains-1)*p_slot_len cycles plus round-robin wait within its own slots. This bound is independent of other domains' traffic.
- **Simultaneous events:** a grant and a slot wrap on the same edge both take effect. The pointer update targets the domain that owned the cycle of the grant.

## Test plan
- **Reset:** hold `reset`=1 with `reqs`=3'b111 and `out_rdy`=1 -> `grants`=0, `out_val`=0, `cur_domain`=0. After release, `cur_domain` reads 0,0,0,0,1,1,1,1,0 over 9 cycles (p_slot_len=4).
- **Round-robin, `tp_en`=0:** `reqs`=3'b111 held, `out_rdy`=1 -> `grants` sequence 001,010,100,001. Drop `reqs[1]` after the first grant -> 001,100,001,100.
- **TDM filtering, `tp_en`=1:** requester 0 in domain 1, requester 2 in domain 0, both requesting from reset -> requester 2 granted in cycles 0-3. Requester 0 is first granted in cycle 4, and requester 2 is not granted in cycles 4-7.
- **Domain isolation:** domain 1 traffic only from requester 1, with requesters 0 and 2 in domain 0 contending -> domain-0 grant order 001,100,001 is unchanged whether requester 1 requests or not.
- **Backpressure:** `out_rdy`=0 for 3 cycles with `reqs`=3'b011 -> `grants`=0, `out_val`=1, `out_sel`=0 throughout. After `out_rdy` rises, `grants`=001 and then 010.
- **Reset mid-slot:** assert `reset` at `slot_cnt`=2 in domain 1 with the domain-1 pointer advanced -> after release, domain 0 slot starts at count 0 and domain-1 priority is back to requester 0.
